// File: rtl/cla_pkg.sv
// cla_pkg: shared geometry helpers for the pipelined CLA adder.
// Group width and stage-count / legality functions.
package cla_pkg;

  localparam int GRP_W = 4;

  function automatic int nseg(input int width, input int seg_w);
    return width / seg_w;
  endfunction

  function automatic bit geom_ok(input int width, input int seg_w);
    return (seg_w > 0) && (width >= seg_w) && ((width % seg_w) == 0);
  endfunction

endpackage

// File: rtl/cla_seg.sv
// cla_seg: combinational SEG_W-bit carry-lookahead segment.
// 4-bit groups with full lookahead across groups.
module cla_seg
  import cla_pkg::*;
#(
  parameter int SEG_W = 8
) (
  input  logic [SEG_W-1:0] x,
  input  logic [SEG_W-1:0] y,
  input  logic             c0,
  output logic [SEG_W-1:0] s,
  output logic             c_out,
  output logic             gx,
  output logic             px
);

  localparam int NG = (SEG_W + GRP_W - 1) / GRP_W;
  localparam int PW = NG * GRP_W;

  logic [PW-1:0] g;
  logic [PW-1:0] p;
  logic [PW-1:0] c;
  logic [NG-1:0] gg;
  logic [NG-1:0] gp;
  logic [NG:0]   cg;

  // Bit g/p; pad bits propagate so a partial top group stays exact.
  always_comb begin
    g = '0;
    p = '1;
    for (int i = 0; i < SEG_W; i++) begin
      g[i] = x[i] & y[i];
      p[i] = x[i] ^ y[i];
    end
  end

  // Group generate/propagate terms.
  always_comb begin
    logic t;
    t  = 1'b0;
    gg = '0;
    gp = '0;
    for (int j = 0; j < NG; j++) begin
      gp[j] = &p[j*GRP_W +: GRP_W];
      for (int b = 0; b < GRP_W; b++) begin
        t = g[j*GRP_W + b];
        for (int m = b + 1; m < GRP_W; m++) begin
          t = t & p[j*GRP_W + m];
        end
        gg[j] = gg[j] | t;
      end
    end
  end

  // Group carry-ins, each a flat sum of products from c0.
  always_comb begin
    logic t;
    t     = 1'b0;
    cg    = '0;
    cg[0] = c0;
    for (int i = 1; i <= NG; i++) begin
      t = c0;
      for (int j = 0; j < i; j++) begin
        t = t & gp[j];
      end
      cg[i] = t;
      for (int j = 0; j < i; j++) begin
        t = gg[j];
        for (int m = j + 1; m < i; m++) begin
          t = t & gp[m];
        end
        cg[i] = cg[i] | t;
      end
    end
  end

  // Segment generate, independent of c0.
  always_comb begin
    logic t;
    t  = 1'b0;
    gx = 1'b0;
    for (int j = 0; j < NG; j++) begin
      t = gg[j];
      for (int m = j + 1; m < NG; m++) begin
        t = t & gp[m];
      end
      gx = gx | t;
    end
  end

  // Short in-group carries seeded by the group carry-in.
  always_comb begin
    c = '0;
    for (int j = 0; j < NG; j++) begin
      c[j*GRP_W] = cg[j];
      for (int b = 1; b < GRP_W; b++) begin
        c[j*GRP_W + b] = g[j*GRP_W + b - 1]
                       | (p[j*GRP_W + b - 1] & c[j*GRP_W + b - 1]);
      end
    end
  end

  assign px    = &gp;
  assign c_out = cg[NG];
  assign s     = p[SEG_W-1:0] ^ c[SEG_W-1:0];

endmodule

// File: rtl/cla_pipe_adder.sv
// cla_pipe_adder: pipelined CLA add/sub, one segment per stage.
// Define CLA_PIPE_OVF_EN to add the signed-overflow output ovf.
module cla_pipe_adder
  import cla_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SEG_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef CLA_PIPE_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NSEG = nseg(WIDTH, SEG_W);

  if (!geom_ok(WIDTH, SEG_W)) begin : g_bad_geom
    $error("cla_pipe_adder: WIDTH must be a multiple of SEG_W");
  end

  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] a_rem;
    logic [WIDTH-1:0] b_rem;
    logic [WIDTH-1:0] sum_acc;
    logic             carry;
  } stage_t;

  stage_t head;
  stage_t tail;
  stage_t pipe [NSEG+1];
  logic   adv;
  logic   unused_tail;

  assign adv      = !tail.valid || out_ready;
  assign in_ready = adv;

  // Stage-0 record: subtract inverts B and forces the carry-in.
  always_comb begin
    head         = '0;
    head.valid   = in_valid;
    head.a_rem   = a;
    head.b_rem   = sub ? ~b : b;
    head.sum_acc = '0;
    head.carry   = sub ? 1'b1 : cin;
  end

  assign pipe[0] = head;

`ifdef CLA_PIPE_OVF_EN
  logic msb_s;
`endif

  for (genvar k = 0; k < NSEG; k++) begin : g_stg
    stage_t           cur;
    stage_t           q;
    logic [SEG_W-1:0] s;
    logic             c_out;
    logic             gx;
    logic             px;
    logic             unused_gp;

    assign cur       = pipe[k];
    assign unused_gp = gx ^ px;

    cla_seg #(
      .SEG_W(SEG_W)
    ) u_seg (
      .x    (cur.a_rem[k*SEG_W +: SEG_W]),
      .y    (cur.b_rem[k*SEG_W +: SEG_W]),
      .c0   (cur.carry),
      .s    (s),
      .c_out(c_out),
      .gx   (gx),
      .px   (px)
    );

    // Advance stage k, folding in this segment's sum and carry.
    always_ff @(posedge clk) begin
      if (rst) begin
        q <= '0;
      end else if (adv) begin
        q.valid <= cur.valid;
        if (cur.valid) begin
          q.a_rem                     <= cur.a_rem;
          q.b_rem                     <= cur.b_rem;
          q.sum_acc                   <= cur.sum_acc;
          q.sum_acc[k*SEG_W +: SEG_W] <= s;
          q.carry                     <= c_out;
        end
      end
    end

    assign pipe[k+1] = q;

`ifdef CLA_PIPE_OVF_EN
    if (k == NSEG - 1) begin : g_msb
      assign msb_s = s[SEG_W-1];
    end
`endif
  end

  assign tail        = pipe[NSEG];
  assign out_valid   = tail.valid;
  assign sum         = tail.sum_acc;
  assign cout        = tail.carry;
  assign unused_tail = ^{tail.a_rem, tail.b_rem};

`ifdef CLA_PIPE_OVF_EN
  logic ovf_q;
  logic a_msb;
  logic b_msb;
  logic last_v;

  assign a_msb  = pipe[NSEG-1].a_rem[WIDTH-1];
  assign b_msb  = pipe[NSEG-1].b_rem[WIDTH-1];
  assign last_v = pipe[NSEG-1].valid;

  // Signed overflow from last-stage operand MSBs and result MSB.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (adv && last_v) begin
      ovf_q <= (a_msb == b_msb) && (msb_s != a_msb);
    end
  end

  assign ovf = ovf_q;
`endif

endmodule
